alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_unit.sv | 163 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Registered decode-and-execute ALU with valid/ready handshakes on both sides.
// Single-cycle ops (SUB/ADD/OR/AND/LT/EQ, and SRA/ROL by zero) load the result
// on the accept edge; SRA/ROL by a non-zero amount step one bit per cycle in
// the SHIFT state and load the result on the edge where the count runs out.
module alu_exec_unit #(
  parameter int WIDTH   = 4,
  parameter int SHAMT_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   rs,
  input  logic [WIDTH-1:0]   rt,
  input  logic [2:0]         sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   rd,
  output logic               cout,
  output logic               zero
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [SHAMT_W:0] WIDTH_EXT = (SHAMT_W+1)'(WIDTH);

  state_t               state_q, state_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]     work_q, work_d;
  logic                 rol_q, rol_d;
  logic [WIDTH-1:0]     rd_q, rd_d;
  logic                 cout_q, cout_d;
  logic                 zero_q, zero_d;
  logic                 vld_q, vld_d;

  logic                 accept;
  logic                 is_shift;
  logic [SHAMT_W-1:0]   sra_amt;
  logic [SHAMT_W:0]     rol_ext;
  logic [SHAMT_W-1:0]   rol_amt;
  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH:0]       alu_res;
  logic [WIDTH-1:0]     step;

  // Single-cycle result as {carry, value}; shift ops here are the zero-amount case.
  function automatic logic [WIDTH:0] alu_op(input logic [2:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    r = '0;
    case (op)
      3'd0: r = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      3'd1: r = {1'b0, a} + {1'b0, b};
      3'd2: r = {1'b0, a | b};
      3'd3: r = {1'b0, a & b};
      3'd4: r = {1'b0, b};
      3'd5: r = {1'b0, a};
      3'd6: begin
        for (int i = 1; i < WIDTH; i++) begin
          r[i] = (((WIDTH - 1 - i) % 2) == 0);
        end
        r[0] = (a < b);
      end
      default: r = {1'b0, {(WIDTH-1){1'b1}}, (a == b)};
    endcase
    return r;
  endfunction

  // One-bit arithmetic right shift, sign filled from the MSB.
  function automatic logic [WIDTH-1:0] sra1(input logic [WIDTH-1:0] x);
    return {x[WIDTH-1], x[WIDTH-1:1]};
  endfunction

  // One-bit left rotate.
  function automatic logic [WIDTH-1:0] rol1(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], x[WIDTH-1]};
  endfunction

  assign in_ready = (state_q == IDLE) && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_shift = (sel[2:1] == 2'b10);
  assign sra_amt  = rs[SHAMT_W-1:0];
  // Rotate amount is taken modulo WIDTH (only matters for non-power-of-two WIDTH).
  assign rol_ext  = {1'b0, rt[SHAMT_W-1:0]};
  assign rol_amt  = (rol_ext >= WIDTH_EXT) ? SHAMT_W'(rol_ext - WIDTH_EXT)
                                           : rt[SHAMT_W-1:0];
  assign shamt    = sel[0] ? rol_amt : sra_amt;
  assign alu_res  = alu_op(sel, rs, rt);
  assign step     = rol_q ? rol1(work_q) : sra1(work_q);

  // Next-state logic: handshake bookkeeping, result load and shift sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    rol_d   = rol_q;
    rd_d    = rd_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    vld_d   = vld_q;
    if (vld_q && out_ready) begin
      vld_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift && (shamt != '0)) begin
            state_d = SHIFT;
            cnt_d   = shamt;
            work_d  = sel[0] ? rs : rt;
            rol_d   = sel[0];
          end else begin
            rd_d   = alu_res[WIDTH-1:0];
            cout_d = alu_res[WIDTH];
            zero_d = (alu_res[WIDTH-1:0] == '0);
            vld_d  = 1'b1;
          end
        end
      end
      SHIFT: begin
        work_d = step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          rd_d    = step;
          cout_d  = 1'b0;
          zero_d  = (step == '0);
          vld_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset also aborts any shift in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      rol_q   <= 1'b0;
      rd_q    <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      rol_q   <= rol_d;
      rd_q    <= rd_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      vld_q   <= vld_d;
    end
  end

  assign rd        = rd_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (WIDTH=4): stimulus pushes expected results
// into a scoreboard queue, a negedge monitor pops and compares each result the
// DUT hands over.
module tb_alu_exec_unit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] rs;
  logic [3:0] rt;
  logic [2:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] rd;
  logic       cout;
  logic       zero;

  typedef struct packed {
    logic [3:0] rd;
    logic       c;
    logic       z;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  alu_exec_unit #(.WIDTH(4), .SHAMT_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs(rs), .rt(rt), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd(rd), .cout(cout), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Scoreboard monitor: a result is consumed on the next edge when valid && ready.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got rd=%0d c=%0d z=%0d", rd, cout, zero);
      end else begin
        e = sb_q.pop_front();
        if (rd !== e.rd || cout !== e.c || zero !== e.z) begin
          errors++;
          $display("FAIL result got rd=%0d c=%0d z=%0d expected rd=%0d c=%0d z=%0d",
                   rd, cout, zero, e.rd, e.c, e.z);
        end
      end
    end
  end

  // Present one op, wait (bounded) for in_ready, record expectation, pass the accept edge.
  task automatic send(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] erd, input logic ec, input logic ez,
                      input bit push, output int waited);
    sel = s; rs = a; rt = b; in_valid = 1'b1;
    #1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout got in_ready=0 expected 1");
    end
    if (push) sb_q.push_back(exp_t'({erd, ec, ez}));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count cycles from the accept cycle until out_valid rises.
  task automatic lat(input string nm, input int exp);
    int c;
    c = 1;
    while (!out_valid && c < 20) begin
      @(posedge clk); #1; c++;
    end
    chk(nm, c, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    rs = '0; rt = '0; sel = '0;
    #3;
    chk("reset_rd", rd, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_cout", cout, 0);
    chk("reset_zero", zero, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_reset", in_ready, 1);

    // Arithmetic: ADD with carry-out, leaves rd/cout non-zero for the reset test.
    send(3'd1, 4'd7, 4'd10, 4'd1, 1'b1, 1'b0, 1'b1, w);
    idle(2);

    // Reset mid-shift: SRA by 3 in flight, then async reset.
    send(3'd4, 4'd3, 4'b1000, 4'd0, 1'b0, 1'b0, 1'b0, w);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_async_rd", rd, 0);
    chk("rst_async_cout", cout, 0);
    chk("rst_async_zero", zero, 0);
    chk("rst_async_out_valid", out_valid, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_release", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("no_stale_result", seen, 0);

    // Arithmetic: SUB equal (zero, no borrow) and SUB with borrow.
    send(3'd0, 4'd3, 4'd3, 4'd0, 1'b1, 1'b1, 1'b1, w);
    send(3'd0, 4'd2, 4'd5, 4'd13, 1'b0, 1'b0, 1'b1, w);
    idle(2);

    // Streaming: OR then AND on consecutive cycles.
    send(3'd2, 4'b0101, 4'b0011, 4'b0111, 1'b0, 1'b0, 1'b1, w);
    chk("stream_rd0", rd, 4'b0111);
    chk("stream_in_ready", in_ready, 1);
    send(3'd3, 4'b0101, 4'b0011, 4'b0001, 1'b0, 1'b0, 1'b1, w);
    chk("stream_no_wait", w, 0);
    chk("stream_rd1", rd, 4'b0001);
    chk("stream_valid1", out_valid, 1);
    idle(2);

    // Shift: SRA 1000 by 3 -> 1111 four cycles after accept.
    send(3'd4, 4'd3, 4'b1000, 4'b1111, 1'b0, 1'b0, 1'b1, w);
    for (int k = 0; k < 3; k++) begin
      chk("sra3_in_ready_low", in_ready, 0);
      chk("sra3_out_valid_low", out_valid, 0);
      @(posedge clk); #1;
    end
    chk("sra3_out_valid", out_valid, 1);
    chk("sra3_rd", rd, 4'b1111);
    idle(2);
    send(3'd5, 4'b1001, 4'd1, 4'b0011, 1'b0, 1'b0, 1'b1, w);
    lat("rol1_latency", 2);
    idle(2);
    send(3'd4, 4'd0, 4'b1010, 4'b1010, 1'b0, 1'b0, 1'b1, w);
    lat("sra0_latency", 1);
    idle(2);

    // Backpressure: ADD 1+1 held for 5 cycles, then consume and accept together.
    out_ready = 1'b0;
    send(3'd1, 4'd1, 4'd1, 4'b0010, 1'b0, 1'b0, 1'b1, w);
    sel = 3'd7; rs = 4'd6; rt = 4'd6; in_valid = 1'b1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (out_valid !== 1'b1 || rd !== 4'b0010 || in_ready !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    chk("backpressure_hold", seen, 0);
    out_ready = 1'b1;
    #1;
    chk("backpressure_release_ready", in_ready, 1);
    sb_q.push_back(exp_t'({4'b1111, 1'b0, 1'b0}));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("same_edge_valid", out_valid, 1);
    chk("same_edge_rd", rd, 4'b1111);
    idle(2);

    // Compare ops.
    send(3'd6, 4'd2, 4'd9, 4'b1011, 1'b0, 1'b0, 1'b1, w);
    send(3'd6, 4'd9, 4'd2, 4'b1010, 1'b0, 1'b0, 1'b1, w);
    send(3'd7, 4'd6, 4'd6, 4'b1111, 1'b0, 1'b0, 1'b1, w);
    send(3'd7, 4'd6, 4'd7, 4'b1110, 1'b0, 1'b0, 1'b1, w);
    idle(4);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
